// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - drives one DSP48A1 slice through clear/accumulate/drain to compute an unsigned dot product
module dsp_mac_sequencer #(
    parameter int LAT      = 3,
    parameter int OPM_SKEW = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [7:0]  LEN,
    output logic        BUSY,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [17:0] IN_A,
    input  logic [17:0] IN_B,
    output logic [17:0] DSP_A,
    output logic [17:0] DSP_B,
    output logic [7:0]  DSP_OPMODE,
    output logic        DSP_CE,
    output logic        DSP_RST,
    input  logic [47:0] DSP_P,
    output logic [47:0] RESULT,
    output logic        DONE
);

    localparam logic [7:0] LAT_CNT = 8'(LAT);
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic [7:0]  len_q;
    logic [47:0] result_q;
    logic        rst_q;
    logic [7:0]  issue_opm;
    logic [7:0]  opm_out;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (START) state_next = (LEN != 8'd0) ? CLR : FIN;
            CLR:     state_next = RUN;
            RUN:     if (IN_VALID && cnt == 8'd1) state_next = DRAIN;
            DRAIN:   if (cnt == 8'd1) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // cnt holds remaining pairs in RUN, then is reused as the drain countdown.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt      <= 8'd0;
            len_q    <= 8'd0;
            result_q <= 48'd0;
            rst_q    <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        len_q <= LEN;
                        if (LEN == 8'd0) result_q <= 48'd0;
                    end
                end
                CLR: cnt <= len_q;
                RUN: begin
                    if (IN_VALID) cnt <= (cnt == 8'd1) ? LAT_CNT : cnt - 8'd1;
                end
                DRAIN: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) result_q <= DSP_P;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        BUSY      = 1'b0;
        IN_READY  = 1'b0;
        DSP_A     = 18'd0;
        DSP_B     = 18'd0;
        DSP_CE    = 1'b0;
        DSP_RST   = RST | rst_q;
        DONE      = 1'b0;
        issue_opm = 8'h00;
        RESULT    = RST ? 48'd0 : result_q;
        if (!RST) begin
            case (state)
                CLR: begin
                    BUSY    = 1'b1;
                    DSP_RST = 1'b1;
                    DSP_CE  = 1'b1;
                end
                RUN: begin
                    BUSY      = 1'b1;
                    IN_READY  = 1'b1;
                    DSP_CE    = IN_VALID;
                    DSP_A     = IN_VALID ? IN_A : 18'd0;
                    DSP_B     = IN_VALID ? IN_B : 18'd0;
                    issue_opm = (cnt == len_q) ? OPM_FIRST : OPM_ACC;
                end
                DRAIN: begin
                    BUSY      = 1'b1;
                    DSP_CE    = 1'b1;
                    issue_opm = OPM_ACC;
                end
                FIN: begin
                    BUSY = 1'b1;
                    DONE = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Opmode must reach the slice's OPMODE register in step with the product it selects.
    generate
        if (OPM_SKEW == 0) begin : g_no_skew
            assign opm_out = issue_opm;
        end else begin : g_skew
            logic [7:0] chain [OPM_SKEW];
            always_ff @(posedge CLK) begin
                if (RST || state == CLR) begin
                    for (int i = 0; i < OPM_SKEW; i++) chain[i] <= 8'h00;
                end else if (DSP_CE) begin
                    chain[0] <= issue_opm;
                    for (int i = 1; i < OPM_SKEW; i++) chain[i] <= chain[i-1];
                end
            end
            assign opm_out = chain[OPM_SKEW-1];
        end
    endgenerate

    assign DSP_OPMODE = RST ? 8'h00 : opm_out;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - randomized and directed bench for dsp_mac_sequencer with a DSP48A1 slice model
module tb_dsp_mac_sequencer;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len_in = 8'd0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_a = 18'd0;
    logic [17:0] in_b = 18'd0;
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [7:0]  dsp_opmode;
    logic        dsp_ce;
    logic        dsp_rst;
    logic [47:0] dsp_p;
    logic [47:0] result;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    logic [17:0] ja [256];
    logic [17:0] jb [256];

    dsp_mac_sequencer #(.LAT(LAT), .OPM_SKEW(1)) dut (
        .CLK(clk), .RST(rst), .START(start), .LEN(len_in), .BUSY(busy),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_A(in_a), .IN_B(in_b),
        .DSP_A(dsp_a), .DSP_B(dsp_b), .DSP_OPMODE(dsp_opmode), .DSP_CE(dsp_ce),
        .DSP_RST(dsp_rst), .DSP_P(dsp_p), .RESULT(result), .DONE(done)
    );

    always #5 clk = ~clk;

    // Slice model: A1/B1 register, M register, OPMODE register, P register.
    logic [17:0] s_a1, s_b1;
    logic [35:0] s_m;
    logic [7:0]  s_opm;
    logic [47:0] s_p;
    always @(posedge clk) begin
        if (dsp_rst) begin
            s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_opm <= '0; s_p <= '0;
        end else if (dsp_ce) begin
            s_a1  <= dsp_a;
            s_b1  <= dsp_b;
            s_m   <= 36'(s_a1) * 36'(s_b1);
            s_opm <= dsp_opmode;
            s_p   <= ((s_opm[3:2] == 2'b10) ? s_p : 48'd0) +
                     ((s_opm[1:0] == 2'b01) ? {12'd0, s_m} : 48'd0);
        end
    end
    assign dsp_p = s_p;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".dsp_rst"}, 64'(dsp_rst), 64'd1);
        check({tag, ".dsp_ce"}, 64'(dsp_ce), 64'd0);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd0);
        check({tag, ".done"}, 64'(done), 64'd0);
        check({tag, ".result"}, 64'(result), 64'd0);
        check({tag, ".opmode"}, 64'(dsp_opmode), 64'd0);
        check({tag, ".dsp_ab"}, 64'({dsp_a, dsp_b}), 64'd0);
    endtask

    // bmode: 0 no bubbles, 1 random bubbles, 2 two bubbles after the second pair
    task automatic run_job(input string tag, input int len, input int bmode, input bit hold,
                           input int tail, output logic [47:0] got);
        logic [63:0] exp_sum = 0;
        int c = 0, idx = 0, bub = 0, dones = 0, ce_hi = 0, done_c = -1, gap = 0;
        got = '0;
        for (int i = 0; i < len; i++) exp_sum = exp_sum + 64'(ja[i]) * 64'(jb[i]);
        exp_sum = exp_sum & 64'h0000_FFFF_FFFF_FFFF;
        @(negedge clk);
        start = 1'b1; len_in = 8'(len); in_valid = 1'b0;
        while (done_c < 0 && c < 3000) begin
            @(negedge clk);
            c++;
            if (dsp_ce) ce_hi++;
            if (done) begin
                done_c = c;
                dones++;
                got = result;
                check({tag, ".result"}, 64'(result), exp_sum);
            end
            start = hold && (done_c < 0);
            in_valid = 1'b0; in_a = '0; in_b = '0;
            if (in_ready && done_c < 0 && idx < len) begin
                if (bmode == 1 && $urandom_range(3) == 0) begin
                    bub++;
                end else if (bmode == 2 && idx == 2 && gap < 2) begin
                    gap++; bub++;
                end else begin
                    in_valid = 1'b1; in_a = ja[idx]; in_b = jb[idx]; idx++;
                end
            end
        end
        start = 1'b0;
        if (done_c < 0) begin
            check({tag, ".timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, ".latency"}, 64'(done_c), (len == 0) ? 64'd1 : 64'(2 + len + LAT + bub));
        end
        for (int i = 0; i < tail; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check({tag, ".done_count"}, 64'(dones), 64'd1);
        if (len == 0) check({tag, ".ce_never"}, 64'(ce_hi), 64'd0);
    endtask

    logic [47:0] r;

    initial begin
        // reset state while held and in the cycle after release
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_hold");
        rst = 1'b0;
        #1;
        check_idle_outputs("reset_after");
        @(negedge clk);
        check({"post_reset", ".dsp_rst"}, 64'(dsp_rst), 64'd0);

        // basic job
        ja[0] = 1; jb[0] = 2; ja[1] = 3; jb[1] = 4; ja[2] = 5; jb[2] = 6; ja[3] = 7; jb[3] = 8;
        run_job("len4", 4, 0, 1'b0, 2, r);
        check("len4.const", 64'(r), 64'd100);

        run_job("len4_bubble", 4, 2, 1'b0, 2, r);
        check("len4_bubble.const", 64'(r), 64'd100);

        run_job("len0", 0, 0, 1'b0, 2, r);
        check("len0.const", 64'(r), 64'd0);

        for (int i = 0; i < 3; i++) begin ja[i] = 18'h3FFFF; jb[i] = 18'h3FFFF; end
        run_job("len3_max_hold", 3, 0, 1'b1, 4, r);
        check("len3_max.const", 64'(r), 64'd206156857347);

        // abort after the second pair of a LEN=4 job
        @(negedge clk); start = 1'b1; len_in = 8'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_a = 18'd1; in_b = 18'd2;
        @(negedge clk); in_a = 18'd3; in_b = 18'd4;
        @(negedge clk); in_valid = 1'b0; in_a = '0; in_b = '0; rst = 1'b1;
        #1;
        check_idle_outputs("abort_hold");
        @(negedge clk); rst = 1'b0;
        #1;
        check_idle_outputs("abort_after");
        begin
            int extra_done = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done || result != 48'd0 || busy) extra_done++;
            end
            check("abort.quiet", 64'(extra_done), 64'd0);
        end
        ja[0] = 10; jb[0] = 10; ja[1] = 20; jb[1] = 20;
        run_job("after_abort", 2, 0, 1'b0, 0, r);
        check("after_abort.const", 64'(r), 64'd500);

        // back-to-back: START in the cycle right after DONE
        ja[0] = 6; jb[0] = 7;
        run_job("b2b", 1, 0, 1'b0, 2, r);
        check("b2b.const", 64'(r), 64'd42);

        // randomized jobs with random bubbles
        for (int j = 0; j < 10; j++) begin
            int l;
            l = (j == 0) ? 1 : $urandom_range(1, 24);
            for (int i = 0; i < l; i++) begin
                ja[i] = 18'($urandom_range(0, 18'h3FFFF));
                jb[i] = 18'($urandom_range(0, 18'h3FFFF));
            end
            run_job($sformatf("rand%0d", j), l, 1, 1'($urandom_range(1)), 2, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dsp_mac_sequencer.md
DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 Parameter LAT, default 3: DSP48A1 operand-to-P latency in CE-enabled cycles (A1REG+MREG+PREG).
REQ-002 Parameter OPM_SKEW, default 1: CE-enabled cycles by which DSP_OPMODE lags the operands it belongs to.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 START  in  1  request a new dot-product job; sampled in IDLE only.
REQ-006 LEN  in  8  number of operand pairs; latched with START.
REQ-007 BUSY  out  1  high in every state except IDLE.
REQ-008 IN_VALID / IN_READY  in / out  1 / 1  operand-pair handshake; transfer when both high.
REQ-009 IN_A, IN_B  in  18 each  operand pair.
REQ-010 DSP_A, DSP_B  out  18 each  to slice A and B ports (B_INPUT DIRECT).
REQ-011 DSP_OPMODE  out  8  to slice OPMODE.
REQ-012 DSP_CE  out  1  common clock enable to all slice CE inputs.
REQ-013 DSP_RST  out  1  common reset to all slice RST inputs.
REQ-014 DSP_P  in  48  slice P output.
REQ-015 RESULT  out  48  captured accumulation; held until next DONE.
REQ-016 DONE  out  1  one-cycle pulse; RESULT valid from this cycle.

Function
REQ-017 States IDLE, CLR, RUN, DRAIN, FIN; encoding free.
REQ-018 IDLE: START=1 and LEN!=0 -> CLR; START=1 and LEN=0 -> FIN with RESULT captured as 0; else stay.
REQ-019 START outside IDLE is ignored; LEN is not re-sampled.
REQ-020 CLR lasts exactly one cycle: DSP_RST=1, DSP_CE=1, remaining-pair counter loaded with LEN -> RUN.
REQ-021 RUN: IN_READY=1; DSP_CE=IN_VALID; on transfer DSP_A/DSP_B present IN_A/IN_B combinationally and counter decrements.
REQ-022 RUN with IN_VALID=0: DSP_CE=0, slice pipeline frozen, no state change (bubble).
REQ-023 Opmode issued with first pair of a job = 8'h01 (X=M, Z=0); all later pairs and drain cycles = 8'h09 (X=M, Z=P); carry-in 0.
REQ-024 Issued opmode passes through an OPM_SKEW-deep register chain advanced only when DSP_CE=1; chain cleared in CLR.
REQ-025 Transfer of the last pair (counter=1) -> DRAIN.
REQ-026 DRAIN: IN_READY=0, DSP_CE=1, DSP_A=DSP_B=0, lasts exactly LAT cycles -> FIN.
REQ-027 FIN lasts one cycle: DONE=1, RESULT<=DSP_P (or 0 for LEN=0) -> IDLE.
REQ-028 Arithmetic unsigned, modulo 2^48; overflow wraps silently, no flag.
REQ-029 With IN_VALID held high, DONE asserts exactly 2+LEN+LAT cycles after the START-sampling edge; each bubble cycle adds one.
REQ-030 IN_READY=0, DSP_A=DSP_B=0, DSP_CE=0 in IDLE and FIN.

Reset
REQ-031 RST=1 forces IDLE on the next edge from any state, aborting any job mid-run or mid-drain.
REQ-032 While RST=1 and in the cycle after: DSP_RST=1, DSP_CE=0; all other outputs 0, including RESULT, DONE, BUSY, IN_READY, DSP_OPMODE.
REQ-033 Counter and opmode chain reset to 0; no partial RESULT is ever captured after reset.

Verification
REQ-034 LEN=4, pairs (1,2),(3,4),(5,6),(7,8), IN_VALID constant -> DONE at cycle 9 after START (LAT=3), RESULT=100.
REQ-035 Same job with IN_VALID low for 2 cycles between pairs 2 and 3 -> RESULT=100, DONE at cycle 11.
REQ-036 LEN=0 -> DONE one cycle after START, RESULT=0, DSP_CE never high.
REQ-037 LEN=3, all operands 18'h3FFFF -> RESULT=206156857347; then START held high during job -> only one DONE.
REQ-038 RST pulsed after 2nd pair of LEN=4 job -> IDLE, RESULT=0, no DONE; new job LEN=2 (10,10),(20,20) -> RESULT=500.
REQ-039 Back-to-back: START in cycle following DONE, LEN=1 (6,7) -> RESULT=42, no residue from previous accumulation.
